// File: rtl/dac128s085_frame_rx.sv
// DAC128S085 bus monitor: oversamples SYNC/SCLK/DIN on clk, rebuilds 16-bit frames
// and mirrors them into eight 12-bit channel shadow registers.

module dac128s085_sync_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic lvl,
    output logic dly
);
    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign lvl = s2_q;
    assign dly = s3_q;
endmodule

module dac128s085_frame_rx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SYNC,
    input  logic        SCLK,
    input  logic        DIN,
    input  logic        ptr_clr,
    output logic [11:0] dac1,
    output logic [11:0] dac2,
    output logic [11:0] dac3,
    output logic [11:0] dac4,
    output logic [11:0] dac5,
    output logic [11:0] dac6,
    output logic [11:0] dac7,
    output logic [11:0] dac8,
    output logic        frame_valid,
    output logic [15:0] frame_data,
    output logic        frame_err,
    output logic [15:0] frame_count,
    output logic [2:0]  chan_ptr
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // lane 0 = SYNC, lane 1 = SCLK; both need the delayed copy for edge detection
    logic [1:0] bus_lvl, bus_dly;
    dac128s085_sync_lane u_lane [1:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({SCLK, SYNC}),
        .lvl   (bus_lvl),
        .dly   (bus_dly)
    );

    // DIN is only ever sampled at its s2 stage, aligned with the SCLK edge detector
    logic din_s1_q, din_s2_q, din_s1_d, din_s2_d;

    logic sync_lvl, sync_fall, sync_rise, sclk_fall, cap;

    state_t            state_q, state_d;
    logic [15:0]       shreg_q, shreg_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic              ovr_q, ovr_d;
    logic [15:0]       frame_data_q, frame_data_d;
    logic              frame_valid_q, frame_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [2:0]        chan_ptr_q, chan_ptr_d;
    logic [7:0][11:0]  dac_q, dac_d;
    logic [15:0]       word;
    logic              accept, ptr_inc;

    always_comb begin
        sync_lvl  = bus_lvl[0];
        sync_fall = bus_dly[0] & ~bus_lvl[0];
        sync_rise = ~bus_dly[0] & bus_lvl[0];
        sclk_fall = bus_dly[1] & ~bus_lvl[1];
        cap       = sclk_fall & ~sync_lvl;
        din_s1_d  = DIN;
        din_s2_d  = din_s1_q;
        word      = {shreg_q[14:0], din_s2_q};
    end

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bitcnt_d      = bitcnt_q;
        ovr_d         = ovr_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        chan_ptr_d    = chan_ptr_q;
        dac_d         = dac_q;
        accept        = 1'b0;
        ptr_inc       = 1'b0;

        case (state_q)
            IDLE: begin
                if (sync_fall) begin
                    bitcnt_d = 5'd0;
                    shreg_d  = 16'd0;
                    ovr_d    = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (sync_rise) begin
                    frame_err_d = 1'b1;
                    bitcnt_d    = 5'd0;
                    state_d     = IDLE;
                end else if (cap) begin
                    shreg_d  = word;
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_q == 5'd15) begin
                        accept  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (cap) ovr_d = 1'b1;
                if (sync_rise) begin
                    frame_err_d = ovr_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // the 16th bit is folded in combinationally so the frame lands on the capture edge
        if (accept) begin
            frame_data_d  = word;
            frame_valid_d = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            if (!word[15]) begin
                dac_d[word[14:12]] = word[11:0];
            end else if (word[15:12] == 4'b1001) begin
                dac_d[chan_ptr_q] = word[11:0];
                ptr_inc           = 1'b1;
            end
        end

        if (ptr_clr)      chan_ptr_d = 3'd0;
        else if (ptr_inc) chan_ptr_d = chan_ptr_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_s1_q      <= 1'b0;
            din_s2_q      <= 1'b0;
            state_q       <= IDLE;
            shreg_q       <= 16'd0;
            bitcnt_q      <= 5'd0;
            ovr_q         <= 1'b0;
            frame_data_q  <= 16'd0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= 16'd0;
            chan_ptr_q    <= 3'd0;
            dac_q         <= '0;
        end else begin
            din_s1_q      <= din_s1_d;
            din_s2_q      <= din_s2_d;
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bitcnt_q      <= bitcnt_d;
            ovr_q         <= ovr_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
            chan_ptr_q    <= chan_ptr_d;
            dac_q         <= dac_d;
        end
    end

    assign dac1        = dac_q[0];
    assign dac2        = dac_q[1];
    assign dac3        = dac_q[2];
    assign dac4        = dac_q[3];
    assign dac5        = dac_q[4];
    assign dac6        = dac_q[5];
    assign dac7        = dac_q[6];
    assign dac8        = dac_q[7];
    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;
    assign chan_ptr    = chan_ptr_q;
endmodule

// File: tb/tb_dac128s085_frame_rx.sv
// Directed bench for dac128s085_frame_rx: drives the serial bus bit by bit, keeps a
// reference model of the shadow registers and a scoreboard of expected frame words.

module tb_dac128s085_frame_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SYNC = 1'b1, SCLK = 1'b1, DIN = 1'b0, ptr_clr = 1'b0;
    logic [11:0] dac1, dac2, dac3, dac4, dac5, dac6, dac7, dac8;
    logic        frame_valid, frame_err;
    logic [15:0] frame_data, frame_count;
    logic [2:0]  chan_ptr;

    dac128s085_frame_rx dut (
        .clk(clk), .rst_n(rst_n), .SYNC(SYNC), .SCLK(SCLK), .DIN(DIN),
        .ptr_clr(ptr_clr),
        .dac1(dac1), .dac2(dac2), .dac3(dac3), .dac4(dac4),
        .dac5(dac5), .dac6(dac6), .dac7(dac7), .dac8(dac8),
        .frame_valid(frame_valid), .frame_data(frame_data), .frame_err(frame_err),
        .frame_count(frame_count), .chan_ptr(chan_ptr)
    );

    always #2.5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, last_fall = 0, valid_cyc = 0;
    int valid_seen = 0, err_seen = 0, valid_exp = 0, err_exp = 0;
    logic [15:0] sb_q[$];
    logic [11:0] exp_dac [8];
    logic [2:0]  exp_ptr = 3'd0;
    logic [15:0] exp_cnt = 16'd0, exp_fd = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] dac_at(input int i);
        case (i)
            0: return dac1;  1: return dac2;  2: return dac3;  3: return dac4;
            4: return dac5;  5: return dac6;  6: return dac7;  default: return dac8;
        endcase
    endfunction

    // scoreboard consumer: every frame_valid pulse must match the oldest pending word
    always @(negedge clk) begin
        if (frame_err) err_seen++;
        if (frame_valid) begin
            valid_seen++;
            valid_cyc = cyc;
            check("sb_pending", 96'(sb_q.size() > 0), 96'(1));
            if (sb_q.size() > 0) check("sb_frame_data", 96'(frame_data), 96'(sb_q.pop_front()));
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) exp_dac[i] = 12'd0;
        exp_ptr = 3'd0;
        exp_cnt = 16'd0;
        exp_fd  = 16'd0;
    endtask

    // sends bits[n-1:0] MSB first; the first 16 form the frame, extras are overrun
    task automatic frame(input logic [17:0] bits, input int n, input bit clr, input bit raise);
        logic [17:0] sh;
        logic [15:0] w;
        if (n >= 16) begin
            sh = bits >> (n - 16);
            w  = sh[15:0];
            sb_q.push_back(w);
            valid_exp++;
            exp_cnt++;
            exp_fd = w;
            if (!w[15]) exp_dac[w[14:12]] = w[11:0];
            else if (w[15:12] == 4'h9) begin
                exp_dac[exp_ptr] = w[11:0];
                exp_ptr = exp_ptr + 3'd1;
            end
        end
        if (clr) exp_ptr = 3'd0;
        if (raise && n != 16) err_exp++;
        SYNC = 1'b0;
        wait_clk(4);
        for (int i = n - 1; i >= 0; i--) begin
            DIN = bits[i];
            wait_clk(4);
            SCLK = 1'b0;
            if (i == n - 16) last_fall = cyc;
            for (int k = 0; k < 4; k++) begin
                ptr_clr = clr && (i == n - 16) && (k == 2);
                @(negedge clk);
            end
            ptr_clr = 1'b0;
            SCLK = 1'b1;
        end
        wait_clk(4);
        if (raise) begin
            SYNC = 1'b1;
            wait_clk(8);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) check($sformatf("%s_dac%0d", tag, i + 1), 96'(dac_at(i)), 96'(exp_dac[i]));
        check({tag, "_count"}, 96'(frame_count), 96'(exp_cnt));
        check({tag, "_ptr"},   96'(chan_ptr),    96'(exp_ptr));
        check({tag, "_fdata"}, 96'(frame_data),  96'(exp_fd));
        check({tag, "_nvalid"}, 96'(valid_seen), 96'(valid_exp));
        check({tag, "_nerr"},  96'(err_seen),    96'(err_exp));
    endtask

    initial begin
        model_reset();
        wait_clk(5);
        check_all("reset");
        check("reset_valid", 96'(frame_valid), 96'(0));
        check("reset_err",   96'(frame_err),   96'(0));
        rst_n = 1'b1;
        wait_clk(5);

        // sequential writes wrap the pointer back to dac1
        for (int i = 0; i < 8; i++) frame(18'(16'h9000 | (i * 16'h111)), 16, 1'b0, 1'b1);
        check_all("seq8");

        frame(18'h05ABC, 16, 1'b0, 1'b1);
        check("addr_latency", 96'(valid_cyc), 96'(last_fall + 3));
        check_all("addr");

        frame(18'h3FF, 10, 1'b0, 1'b1);
        check_all("short");
        frame(18'h09123, 16, 1'b0, 1'b1);
        check_all("after_short");

        frame({16'h9456, 2'b10}, 18, 1'b0, 1'b1);
        check("over_latency", 96'(valid_cyc), 96'(last_fall + 3));
        check_all("overrun");

        frame(18'h09777, 16, 1'b0, 1'b1);
        check("pre_clr_ptr", 96'(chan_ptr), 96'(3));
        frame(18'h09FFF, 16, 1'b1, 1'b1);
        check_all("ptr_clr");

        // reset in the middle of a frame, then a clean addressed frame
        frame(18'h1A, 8, 1'b0, 1'b0);
        rst_n = 1'b0;
        SYNC  = 1'b1;
        model_reset();
        wait_clk(3);
        check_all("mid_reset");
        check("mid_reset_valid", 96'(frame_valid), 96'(0));
        rst_n = 1'b1;
        wait_clk(6);
        frame(18'h01ABC, 16, 1'b0, 1'b1);
        check_all("post_reset");
        check("sb_drained", 96'(sb_q.size()), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
